// File: rtl/cache_miss_sequencer.sv
// Per-request miss/upgrade sequencer driving ACE evict/fill/upgrade pulses ahead of ace_controller.
// Optional statistics counters are compiled in when MISS_STATS_EN is defined.
module cache_miss_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req_valid,
  input  logic             cpu_req_write,
  output logic             cpu_req_ready,
  output logic             cpu_resp_valid,
  output logic             cpu_resp_err,
  input  logic             tag_hit,
  input  logic [1:0]       line_state,
  input  logic             victim_dirty,
  output logic             read_req,
  output logic             write_req,
  output logic             invalid_req,
  input  logic             ace_ready,
  output logic             state_wr_en,
  output logic [1:0]       state_wr_val
`ifdef MISS_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] evict_cnt,
  output logic [CNT_W-1:0] upg_cnt
`endif
);

  localparam int         TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_EVICT_WAIT, S_FILL, S_FILL_WAIT,
    S_UPG, S_UPG_WAIT, S_COMMIT, S_RESP, S_ERR
  } state_t;

  state_t        state_q;
  logic          store_q;
  logic          accepted_q;
  logic [TW-1:0] tmo_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic          wr_en_q;
  logic [1:0]    wr_val_q;

  logic lookup_hit;
  logic in_wait;
  logic wait_done;
  logic tmo_expired;

  assign lookup_hit  = tag_hit && (line_state != MESI_I);
  assign in_wait     = (state_q == S_EVICT_WAIT) || (state_q == S_FILL_WAIT) ||
                       (state_q == S_UPG_WAIT);
  assign wait_done   = in_wait && accepted_q && ace_ready;
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Issue pulses must land in the very cycle ace_ready is high, so they are decoded, not registered.
  assign cpu_req_ready  = !rst && (state_q == S_IDLE);
  assign write_req      = !rst && ace_ready && (state_q == S_EVICT);
  assign read_req       = !rst && ace_ready && (state_q == S_FILL);
  assign invalid_req    = !rst && ace_ready && (state_q == S_UPG);
  assign cpu_resp_valid = !rst && resp_valid_q;
  assign cpu_resp_err   = !rst && resp_err_q;
  assign state_wr_en    = !rst && wr_en_q;
  assign state_wr_val   = {2{!rst}} & wr_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      accepted_q   <= 1'b0;
      tmo_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_val_q     <= 2'b00;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_val_q     <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (cpu_req_valid) begin
            store_q <= cpu_req_write;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            if (!store_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else if (line_state == MESI_S) begin
              state_q <= S_UPG;
            end else begin
              state_q  <= S_COMMIT;
              wr_en_q  <= 1'b1;
              wr_val_q <= MESI_M;
            end
          end else begin
            state_q <= victim_dirty ? S_EVICT : S_FILL;
          end
        end
        S_EVICT, S_FILL, S_UPG: begin
          if (ace_ready) begin
            accepted_q <= 1'b0;
            tmo_q      <= '0;
            if (state_q == S_EVICT)     state_q <= S_EVICT_WAIT;
            else if (state_q == S_FILL) state_q <= S_FILL_WAIT;
            else                        state_q <= S_UPG_WAIT;
          end
        end
        S_EVICT_WAIT, S_FILL_WAIT, S_UPG_WAIT: begin
          if (wait_done) begin
            if (state_q == S_EVICT_WAIT) begin
              state_q <= S_FILL;
            end else if (state_q == S_FILL_WAIT && store_q) begin
              state_q <= S_UPG;
            end else begin
              state_q  <= S_COMMIT;
              wr_en_q  <= 1'b1;
              wr_val_q <= (state_q == S_FILL_WAIT) ? MESI_S : MESI_M;
            end
          end else if (tmo_expired) begin
            state_q      <= S_ERR;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            if (!ace_ready) accepted_q <= 1'b1;
          end
        end
        S_COMMIT: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MISS_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, evict_cnt_q, upg_cnt_q;

  // Saturating counters; they never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
      upg_cnt_q   <= '0;
    end else begin
      if (state_q == S_LOOKUP && lookup_hit && !(&hit_cnt_q))   hit_cnt_q   <= hit_cnt_q + CNT_W'(1);
      if (state_q == S_LOOKUP && !lookup_hit && !(&miss_cnt_q)) miss_cnt_q  <= miss_cnt_q + CNT_W'(1);
      if (write_req && !(&evict_cnt_q))                         evict_cnt_q <= evict_cnt_q + CNT_W'(1);
      if (invalid_req && !(&upg_cnt_q))                         upg_cnt_q   <= upg_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign evict_cnt = evict_cnt_q;
  assign upg_cnt   = upg_cnt_q;
`else
  if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cache_miss_sequencer: CNT_W and TIMEOUT_CYCLES must be positive");
  end
`endif

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Bench for cache_miss_sequencer: directed scenarios plus randomized requests against a transaction-level model.
// Acts as the ace_controller handshake partner; build with MISS_STATS_EN to also check the counters.
module tb_cache_miss_sequencer;

  localparam int TMO   = 256;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req_valid, cpu_req_write, cpu_req_ready;
  logic       cpu_resp_valid, cpu_resp_err;
  logic       tag_hit, victim_dirty;
  logic [1:0] line_state;
  logic       read_req, write_req, invalid_req, ace_ready;
  logic       state_wr_en;
  logic [1:0] state_wr_val;
`ifdef MISS_STATS_EN
  logic [CNT_W-1:0] hit_cnt, miss_cnt, evict_cnt, upg_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int m_hit = 0, m_miss = 0, m_evict = 0, m_upg = 0;

  always #5 clk = ~clk;

  cache_miss_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_err(cpu_resp_err),
    .tag_hit(tag_hit), .line_state(line_state), .victim_dirty(victim_dirty),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .ace_ready(ace_ready), .state_wr_en(state_wr_en), .state_wr_val(state_wr_val)
`ifdef MISS_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt), .upg_cnt(upg_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected ACE pulse order folded into base-4 digits: 1=write, 2=read, 3=invalid.
  function automatic int model_pulses(input bit wr, input bit hit, input bit [1:0] ls,
                                      input bit vd, input bit hang);
    int q[$];
    int code = 0;
    if (!hit) begin
      if (vd) q.push_back(1);
      q.push_back(2);
      if (wr && !hang) q.push_back(3);
    end else if (wr && ls == 2'b01) begin
      q.push_back(3);
    end
    foreach (q[i]) code = code * 4 + q[i];
    return code;
  endfunction

  task automatic run_txn(input string name, input bit wr, input bit th, input bit [1:0] ls,
                         input bit vd, input int pre_busy, input int acc_lat, input int busy_len,
                         input bit hang);
    bit hit, exp_err, done, err, multi, pulse_not_ready, ready_busy, hang_on;
    int exp_code, exp_commits, exp_val, code, commits, commit_val, kp, resp_k, pb, hold_hi, hold_lo, np;
    hit         = th && (ls != 2'b00);
    exp_code    = model_pulses(wr, hit, ls, vd, hang);
    exp_err     = hang;
    exp_commits = (hang || (hit && !wr)) ? 0 : 1;
    exp_val     = wr ? 3 : 1;
    if (hit) m_hit++; else m_miss++;
    if (!hit && vd) m_evict++;
    if (wr && !hang && (!hit || ls == 2'b01)) m_upg++;

    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = wr; tag_hit = th; line_state = ls;
    victim_dirty = vd; ace_ready = 1'b1;
    #1 chk({name, "/req_ready"}, cpu_req_ready, 1);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_write = ~wr;
    code = 0; commits = 0; commit_val = 0; kp = 0; resp_k = 0; done = 0; err = 0;
    multi = 0; pulse_not_ready = 0; ready_busy = 0; hang_on = 0;
    pb = pre_busy; hold_hi = 0; hold_lo = 0;
    for (int k = 1; k <= 600; k++) begin
      if (pb > 0) begin ace_ready = 1'b0; pb--; end
      else if (hold_hi > 0) begin ace_ready = 1'b1; hold_hi--; end
      else if (hold_lo > 0) begin ace_ready = 1'b0; if (!hang_on) hold_lo--; end
      else ace_ready = 1'b1;
      #1;
      np = int'(write_req) + int'(read_req) + int'(invalid_req);
      if (np > 1) multi = 1;
      if (np > 0 && !ace_ready) pulse_not_ready = 1;
      if (np > 0) begin
        code = code * 4 + (write_req ? 1 : read_req ? 2 : 3);
        kp = k; hold_hi = acc_lat; hold_lo = busy_len;
        if (hang && read_req) begin hang_on = 1; hold_hi = 0; hold_lo = 1; end
      end
      if (cpu_req_ready) ready_busy = 1;
      if (state_wr_en) begin commits++; commit_val = int'(state_wr_val); end
      if (cpu_resp_valid) begin done = 1; err = cpu_resp_err; resp_k = k; break; end
      @(negedge clk);
    end
    chk({name, "/resp_seen"}, done, 1);
    chk({name, "/pulse_order"}, code, exp_code);
    chk({name, "/resp_err"}, err, exp_err);
    chk({name, "/commit_count"}, commits, exp_commits);
    if (exp_commits == 1) chk({name, "/commit_val"}, commit_val, exp_val);
    chk({name, "/one_pulse_per_cycle"}, multi, 0);
    chk({name, "/pulse_only_when_ready"}, pulse_not_ready, 0);
    chk({name, "/ready_low_while_busy"}, ready_busy, 0);
    if (hit && !wr) chk({name, "/load_hit_latency"}, resp_k, 2);
    if (hit && wr && ls[1]) chk({name, "/store_hit_em_latency"}, resp_k, 3);
    if (hang) chk({name, "/timeout_window"}, (resp_k - kp >= TMO + 1) && (resp_k - kp <= TMO + 2), 1);
    @(negedge clk);
    ace_ready = 1'b1;
    #1;
    chk({name, "/resp_one_cycle"}, cpu_resp_valid, 0);
    chk({name, "/ready_after_resp"}, cpu_req_ready, 1);
    $display("txn %s wr=%0d hit=%0d ls=%0d vd=%0d pulses=%0d commits=%0d err=%0d lat=%0d",
             name, wr, th, ls, vd, code, commits, err, resp_k);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int resp_cnt;
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; tag_hit = 1'b0;
    line_state = 2'b00; victim_dirty = 1'b0; ace_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset/ready", cpu_req_ready, 0);
    chk("reset/resp_valid", cpu_resp_valid, 0);
    chk("reset/pulses", {write_req, read_req, invalid_req}, 0);
    chk("reset/state_wr", {state_wr_en, state_wr_val}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset/ready_first_idle", cpu_req_ready, 1);

    run_txn("load_hit_S",        0, 1, 2'b01, 0, 0, 0, 1, 0);
    run_txn("store_hit_S",       1, 1, 2'b01, 0, 0, 0, 3, 0);
    run_txn("load_miss_dirty",   0, 0, 2'b00, 1, 0, 1, 2, 0);
    run_txn("store_miss_clean",  1, 0, 2'b10, 0, 4, 0, 2, 0);
    run_txn("store_hit_M",       1, 1, 2'b11, 1, 0, 0, 1, 0);
    run_txn("load_tag_hit_I",    0, 1, 2'b00, 0, 0, 2, 1, 0);
    run_txn("fill_timeout",      0, 0, 2'b00, 0, 0, 0, 1, 1);
    run_txn("after_timeout",     0, 1, 2'b10, 0, 0, 0, 1, 0);

    // Reset in the middle of an upgrade wait must abandon the request silently.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_write = 1'b1; tag_hit = 1'b1; line_state = 2'b01; ace_ready = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (invalid_req) seen = 1;
      @(negedge clk);
      if (seen) begin ace_ready = 1'b0; break; end
    end
    chk("rst_mid/upgrade_issued", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid/outputs_in_reset", {cpu_req_ready, cpu_resp_valid, cpu_resp_err, write_req,
                                     read_req, invalid_req, state_wr_en, state_wr_val}, 0);
    @(negedge clk);
    rst = 1'b0; ace_ready = 1'b1;
    #1;
    chk("rst_mid/idle_ready", cpu_req_ready, 1);
    chk("rst_mid/outputs_idle", {cpu_resp_valid, write_req, read_req, invalid_req, state_wr_en}, 0);
`ifdef MISS_STATS_EN
    chk("rst_mid/counters_zero", {hit_cnt, miss_cnt, evict_cnt, upg_cnt}, 0);
    m_hit = 0; m_miss = 0; m_evict = 0; m_upg = 0;
`endif
    resp_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (cpu_resp_valid || state_wr_en) resp_cnt++;
    end
    chk("rst_mid/no_late_resp", resp_cnt, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
              $urandom_range(0, 3), $urandom_range(1, 5), 0);
    end

`ifdef MISS_STATS_EN
    chk("stats/hit_cnt", hit_cnt, m_hit);
    chk("stats/miss_cnt", miss_cnt, m_miss);
    chk("stats/evict_cnt", evict_cnt, m_evict);
    chk("stats/upg_cnt", upg_cnt, m_upg);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
